// File: rtl/rec_play_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rec_play_pkg
//  Purpose  : Shared widths and the controller state encoding for the
//             record/playback controller.
//  Contents : ADDR_W   - sample memory address width (17)
//             SAMPLE_W - audio sample width (16)
//             state_t  - controller state enum
//  Revision : 1.0 - initial release
// ============================================================================
package rec_play_pkg;

    localparam int ADDR_W   = 17;
    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_REC   = 3'd1,
        RECORD     = 3'd2,
        LOAD_PLAY  = 3'd3,
        PLAY_FETCH = 3'd4,
        PLAY_LOAD  = 3'd5,
        PLAY_WAIT  = 3'd6,
        FINISH     = 3'd7
    } state_t;

endpackage : rec_play_pkg
`default_nettype wire

// File: rtl/record_play_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : record_play_ctrl
//  Purpose  : Record/playback sequencer. Records deserializer samples into a
//             synchronous RAM across an inclusive address window, or plays the
//             window back into a serializer. The address itself comes from an
//             external counter that this block loads via one-cycle strobes.
//  Ports    : clock, reset           - rising-edge clock, sync active-high reset
//             recordReq/playReq/stopReq - level-sampled user commands
//             startAddress/endAddress - inclusive window, captured on accept
//             desDone/desData        - deserializer sample handshake
//             sDone                  - serializer consumed the loaded sample
//             address                - current external counter value
//             memRData               - RAM read data (1-cycle latency)
//             startCountRecord/startCountPlay - counter load strobes
//             memAddr/memWe/memWData - RAM port
//             serLoad/serData        - serializer load strobe and sample
//             recording/playing/done - status and completion pulse
//  Options  : LOOP_PLAY_EN - when defined, playback restarts at the window
//             start after the last sample and only stopReq ends it.
//  Revision : 1.0 - initial release
// ============================================================================
module record_play_ctrl
    import rec_play_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                recordReq,
    input  logic                playReq,
    input  logic                stopReq,
    input  logic [ADDR_W-1:0]   startAddress,
    input  logic [ADDR_W-1:0]   endAddress,
    input  logic                desDone,
    input  logic [SAMPLE_W-1:0] desData,
    input  logic                sDone,
    input  logic [ADDR_W-1:0]   address,
    input  logic [SAMPLE_W-1:0] memRData,
    output logic                startCountRecord,
    output logic                startCountPlay,
    output logic [ADDR_W-1:0]   memAddr,
    output logic                memWe,
    output logic [SAMPLE_W-1:0] memWData,
    output logic                serLoad,
    output logic [SAMPLE_W-1:0] serData,
    output logic                recording,
    output logic                playing,
    output logic                done
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_start;
    logic [ADDR_W-1:0]     r_end;
    logic                  r_serLoad;
    logic [SAMPLE_W-1:0]   r_serData;

    logic                  w_window_ok;
    logic                  w_at_end;
    logic                  w_write;
    logic                  w_unused_start;

    // A reversed window is rejected before any state change or capture.
    assign w_window_ok = (startAddress <= endAddress);
    assign w_at_end    = (address == r_end);

    // The external counter loads its own start value on the strobe, so the
    // captured start register is kept only as a record of the active window.
    assign w_unused_start = ^r_start;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_window_ok) begin
                    if (recordReq) begin
                        w_next = LOAD_REC;
                    end else if (playReq) begin
                        w_next = LOAD_PLAY;
                    end
                end
            end
            LOAD_REC: begin
                w_next = RECORD;
            end
            RECORD: begin
                // Gated by reset so an abort cycle never commits a sample.
                w_write = desDone && !reset;
                if (stopReq || (desDone && w_at_end)) begin
                    w_next = FINISH;
                end
            end
            LOAD_PLAY: begin
                w_next = PLAY_FETCH;
            end
            PLAY_FETCH: begin
                w_next = stopReq ? FINISH : PLAY_LOAD;
            end
            PLAY_LOAD: begin
                w_next = stopReq ? FINISH : PLAY_WAIT;
            end
            PLAY_WAIT: begin
                if (stopReq) begin
                    w_next = FINISH;
                end else if (sDone) begin
                    if (w_at_end) begin
`ifdef LOOP_PLAY_EN
                        w_next = LOAD_PLAY;
`else
                        w_next = FINISH;
`endif
                    end else begin
                        w_next = PLAY_FETCH;
                    end
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_start   <= '0;
            r_end     <= '0;
            r_serLoad <= 1'b0;
            r_serData <= '0;
        end else begin
            r_state   <= w_next;
            r_serLoad <= 1'b0;
            if ((r_state == IDLE) && (w_next != IDLE)) begin
                r_start <= startAddress;
                r_end   <= endAddress;
            end
            // RAM data is valid in PLAY_LOAD; strobe and sample are presented
            // together on the following cycle so the serializer sees a
            // consistent pair. A stop in PLAY_LOAD suppresses the load.
            if ((r_state == PLAY_LOAD) && !stopReq) begin
                r_serData <= memRData;
                r_serLoad <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign startCountRecord = (r_state == LOAD_REC);
    assign startCountPlay   = (r_state == LOAD_PLAY);
    assign recording        = (r_state == LOAD_REC) || (r_state == RECORD);
    assign playing          = (r_state == LOAD_PLAY)  || (r_state == PLAY_FETCH) ||
                              (r_state == PLAY_LOAD)  || (r_state == PLAY_WAIT);
    assign done             = (r_state == FINISH);

    assign memWe    = w_write;
    assign memWData = w_write ? desData : '0;
    assign memAddr  = (w_write || (r_state == PLAY_FETCH)) ? address : '0;

    assign serLoad  = r_serLoad;
    assign serData  = r_serData;

endmodule : record_play_ctrl
`default_nettype wire
